ps2_note_tracker: RTL

PS2_NOTE_TRACKER -- requirements
Module: ps2_note_tracker

---
 rtl/ps2_note_if.sv | 22 ++
 rtl/ps2_note_tracker.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ps2_note_if.sv
// ps2_note_if: scan-code byte input and note-event/state outputs of ps2_note_tracker.
interface ps2_note_if;
    logic [7:0]  received_data;
    logic        received_data_en;
    logic        note_valid;
    logic [3:0]  note_index;
    logic        note_on;
    logic [12:0] held_mask;
    logic [3:0]  active_note;
    logic        active_valid;
    logic [1:0]  octave;

    modport master (
        output received_data, received_data_en,
        input  note_valid, note_index, note_on, held_mask, active_note, active_valid, octave
    );

    modport slave (
        input  received_data, received_data_en,
        output note_valid, note_index, note_on, held_mask, active_note, active_valid, octave
    );
endinterface

// File: rtl/ps2_note_tracker.sv
// ps2_note_tracker: turns PS/2 scan-code bytes into note press/release events and a held-note mask.
// Define PS2_NOTE_OCTAVE_EN to enable octave down/up on make codes 1A/22.
module ps2_note_tracker #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input logic        CLOCK_50,
    input logic        reset,
    ps2_note_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [CW-1:0] cnt;
    logic        timeout;
    logic [4:0]  map;
    logic        hit;
    logic [3:0]  idx;
    logic        ev, on_n;
    logic [12:0] mask, mask_n;
    logic        valid_r, on_r;
    logic [3:0]  index_r, active;

    // {mapped, note} for a make code
    function automatic logic [4:0] note_map(input logic [7:0] b);
        case (b)
            8'h1C: return 5'h10;
            8'h1D: return 5'h11;
            8'h1B: return 5'h12;
            8'h24: return 5'h13;
            8'h23: return 5'h14;
            8'h2B: return 5'h15;
            8'h2C: return 5'h16;
            8'h34: return 5'h17;
            8'h35: return 5'h18;
            8'h33: return 5'h19;
            8'h3C: return 5'h1A;
            8'h3B: return 5'h1B;
            8'h42: return 5'h1C;
            default: return 5'h00;
        endcase
    endfunction

    assign map = note_map(bus.received_data);
    assign hit = map[4];
    assign idx = map[3:0];
    assign timeout = state != IDLE && !bus.received_data_en && cnt == LAST;

`ifdef PS2_NOTE_OCTAVE_EN
    logic [1:0] oct, oct_n;
    always_comb begin
        oct_n = oct;
        if (bus.received_data_en && state == IDLE) begin
            if (bus.received_data == 8'h1A && oct != 2'd0) oct_n = oct - 2'd1;
            if (bus.received_data == 8'h22 && oct != 2'd3) oct_n = oct + 2'd1;
        end
    end
    always_ff @(posedge CLOCK_50) oct <= reset ? 2'd1 : oct_n;
    assign bus.octave = oct;
`else
    assign bus.octave = 2'd1;
`endif

    always_comb begin
        state_n = state;
        mask_n  = mask;
        ev      = 1'b0;
        on_n    = 1'b0;
        if (bus.received_data_en) begin
            if (bus.received_data == 8'hE0) state_n = EXT;
            else if (bus.received_data == 8'hF0) state_n = (state == EXT || state == EXT_BREAK) ? EXT_BREAK : BREAK;
            else begin
                state_n = IDLE;
                if (hit && state == IDLE && !mask[idx]) begin
                    ev          = 1'b1;
                    on_n        = 1'b1;
                    mask_n[idx] = 1'b1;
                end
                if (hit && state == BREAK && mask[idx]) begin
                    ev          = 1'b1;
                    mask_n[idx] = 1'b0;
                end
            end
        end else if (timeout) state_n = IDLE;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            mask    <= '0;
            valid_r <= 1'b0;
            index_r <= '0;
            on_r    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= (bus.received_data_en || state == IDLE || timeout) ? '0 : cnt + 1'b1;
            mask    <= mask_n;
            valid_r <= ev;
            if (ev) begin
                index_r <= idx;
                on_r    <= on_n;
            end
        end
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < 13; i++) if (mask[i]) active = 4'(i);
    end

    assign bus.note_valid   = valid_r;
    assign bus.note_index   = index_r;
    assign bus.note_on      = on_r;
    assign bus.held_mask    = mask;
    assign bus.active_note  = active;
    assign bus.active_valid = |mask;
endmodule
